// File: rtl/serial_word_collector.sv
// Reassembles LSB-first serial frames into WIDTH-bit words for the parallel datapath.
// Output register is separate from the shift register; overrun/frame_err are sticky.
module serial_word_collector #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             frame_start,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             overrun,
    output logic             frame_err,
    input  logic             flag_clr
);

    typedef enum logic {S_IDLE, S_COLLECT} state_t;

    // Count holds bits already collected; the bit arriving at LAST completes the word.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_shift, w_shift_nxt, w_shifted, w_first;
    logic [WIDTH-1:0] r_word;
    logic             r_valid, r_ovr, r_ferr;
    logic             w_done, w_ferr_set, w_ovr_set;

    assign w_shifted = {bit_in, r_shift[WIDTH-1:1]};
    assign w_first   = {bit_in, {(WIDTH-1){1'b0}}};

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_done      = 1'b0;
        w_ferr_set  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bit_valid && frame_start) begin
                    w_shift_nxt = w_first;
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (bit_valid) begin
                    if (frame_start) begin
                        // Truncated frame: drop the partial word, this bit becomes bit 0.
                        w_shift_nxt = w_first;
                        w_cnt_nxt   = CNT_W'(1);
                        w_ferr_set  = 1'b1;
                    end else if (r_cnt == LAST) begin
                        w_shift_nxt = w_shifted;
                        w_cnt_nxt   = '0;
                        w_done      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_shift_nxt = w_shifted;
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_ovr_set = w_done && r_valid && !word_ready;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_word  <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            if (w_done && (!r_valid || word_ready)) begin
                r_word  <= w_shifted;
                r_valid <= 1'b1;
            end else if (r_valid && word_ready) begin
                r_valid <= 1'b0;
            end
            // Set has priority over a coincident clear.
            if (w_ovr_set)     r_ovr <= 1'b1;
            else if (flag_clr) r_ovr <= 1'b0;
            if (w_ferr_set)    r_ferr <= 1'b1;
            else if (flag_clr) r_ferr <= 1'b0;
        end
    end

    assign word_out   = r_word;
    assign word_valid = r_valid;
    assign overrun    = r_ovr;
    assign frame_err  = r_ferr;

endmodule

// File: tb/tb_serial_word_collector.sv
// Randomized + directed bench for serial_word_collector against a bit-queue reference model.
module tb_serial_word_collector;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         areset = 1'b1;
    logic         bit_valid = 1'b0, bit_in = 1'b0, frame_start = 1'b0;
    logic         word_ready = 1'b0, flag_clr = 1'b0;
    logic [W-1:0] word_out;
    logic         word_valid, overrun, frame_err;

    serial_word_collector #(.WIDTH(W)) dut (
        .clk(clk), .areset(areset), .bit_valid(bit_valid), .bit_in(bit_in),
        .frame_start(frame_start), .word_out(word_out), .word_valid(word_valid),
        .word_ready(word_ready), .overrun(overrun), .frame_err(frame_err),
        .flag_clr(flag_clr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0, n_vld = 0;

    // Reference model: bits of the frame in progress, plus the presented word/flags.
    bit           mq[$];
    logic [W-1:0] m_word = '0;
    bit           m_valid = 0, m_ovr = 0, m_ferr = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_word = '0; m_valid = 0; m_ovr = 0; m_ferr = 0;
    endtask

    task automatic model_update(input bit bv, input bit bi, input bit fs, input bit rdy, input bit clr);
        bit           done, fe, ov;
        logic [W-1:0] w;
        done = 0; fe = 0; ov = 0; w = '0;
        if (bv) begin
            if (fs) begin
                fe = (mq.size() != 0);
                mq.delete();
                mq.push_back(bi);
            end else if (mq.size() != 0) begin
                mq.push_back(bi);
                if (mq.size() == W) begin
                    for (int i = 0; i < W; i++) w[i] = mq[i];
                    mq.delete();
                    done = 1;
                end
            end
        end
        if (done) begin
            if (!m_valid || rdy) begin
                m_word  = w;
                m_valid = 1;
            end else begin
                ov = 1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        if (clr) begin m_ovr = 0; m_ferr = 0; end
        if (ov) m_ovr = 1;
        if (fe) m_ferr = 1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".word"},  32'(word_out),   32'(m_word));
        chk({tag, ".valid"}, 32'(word_valid), 32'(m_valid));
        chk({tag, ".ovr"},   32'(overrun),    32'(m_ovr));
        chk({tag, ".ferr"},  32'(frame_err),  32'(m_ferr));
    endtask

    task automatic step(input bit bv, input bit bi, input bit fs, input bit rdy, input bit clr);
        bit_valid = bv; bit_in = bi; frame_start = fs; word_ready = rdy; flag_clr = clr;
        @(posedge clk);
        model_update(bv, bi, fs, rdy, clr);
        #1;
        if (word_valid) n_vld++;
        check_all("step");
    endtask

    // Whole frame, optional idle gap after bit gap_at; rdy_last applies to the final bit only.
    task automatic send_frame(input logic [W-1:0] w, input bit rdy, input bit rdy_last,
                              input int gap_at, input int gap_len);
        for (int i = 0; i < W; i++) begin
            step(1, w[i], i == 0, (i == W-1) ? rdy_last : rdy, 0);
            if (i == gap_at)
                for (int g = 0; g < gap_len; g++) step(0, 1, 0, rdy, 0);
        end
    endtask

    task automatic do_reset();
        areset = 1'b1;
        bit_valid = 0; frame_start = 0; word_ready = 0; flag_clr = 0;
        model_clear();
        #1;
        chk("rst.word",  32'(word_out),   32'h0);
        chk("rst.valid", 32'(word_valid), 32'h0);
        chk("rst.ovr",   32'(overrun),    32'h0);
        chk("rst.ferr",  32'(frame_err),  32'h0);
        @(negedge clk);
        areset = 1'b0;
    endtask

    initial begin
        do_reset();

        // z stream of complementer input 0x14, back-to-back
        send_frame(8'hEC, 1, 1, -1, 0);
        chk("t1.word", 32'(word_out), 32'hEC);
        chk("t1.valid", 32'(word_valid), 32'h1);
        step(0, 0, 0, 1, 0);
        chk("t1.valid_fall", 32'(word_valid), 32'h0);

        // 3-cycle gap between bits 2 and 3
        send_frame(8'hEC, 1, 1, 2, 3);
        chk("t2.word", 32'(word_out), 32'hEC);
        chk("t2.flags", 32'({overrun, frame_err}), 32'h0);
        step(0, 0, 0, 1, 0);

        // backpressure: second word dropped
        send_frame(8'hEC, 0, 0, -1, 0);
        send_frame(8'h5A, 0, 0, -1, 0);
        chk("t3.word", 32'(word_out), 32'hEC);
        chk("t3.ovr", 32'(overrun), 32'h1);
        step(0, 0, 0, 1, 0);
        chk("t3.accept", 32'(word_valid), 32'h0);
        step(0, 0, 0, 0, 1);
        chk("t3.clr", 32'(overrun), 32'h0);

        // truncated frame then 0x01
        step(1, 1, 1, 1, 0);
        step(1, 0, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        n_vld = 0;
        send_frame(8'h01, 1, 1, -1, 0);
        chk("t4.ferr", 32'(frame_err), 32'h1);
        chk("t4.word", 32'(word_out), 32'h01);
        step(0, 0, 0, 1, 0);
        chk("t4.pulses", 32'(n_vld), 32'h1);
        step(0, 0, 0, 0, 1);

        // async reset mid-frame with a held word
        send_frame(8'hEC, 0, 0, -1, 0);
        for (int i = 0; i < 5; i++) step(1, 1, i == 0, 0, 0);
        do_reset();
        send_frame(8'h80, 1, 1, -1, 0);
        chk("t5.word", 32'(word_out), 32'h80);
        chk("t5.flags", 32'({overrun, frame_err}), 32'h0);
        step(0, 0, 0, 1, 0);

        // completion coincides with acceptance of the held word
        send_frame(8'hEC, 0, 0, -1, 0);
        send_frame(8'h33, 0, 1, -1, 0);
        chk("t6.word", 32'(word_out), 32'h33);
        chk("t6.valid", 32'(word_valid), 32'h1);
        chk("t6.ovr", 32'(overrun), 32'h0);
        step(0, 0, 0, 1, 0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit bv, bi, fs, rdy, clr;
            bv  = ($urandom % 4) != 0;
            bi  = $urandom % 2;
            fs  = bv && ((mq.size() == 0) ? ($urandom % 2 == 0) : ($urandom % 12 == 0));
            rdy = ($urandom % 3) != 0;
            clr = ($urandom % 25) == 0;
            step(bv, bi, fs, rdy, clr);
            if ($urandom % 500 == 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_word_collector.md
Name: serial_word_collector

Overview:
- Downstream stage of the bit-serial two's-complement Mealy stage.
- Consumes that stage's LSB-first serial output (z) and its frame markers, and reassembles WIDTH-bit parallel words.
- Presents each word on a valid/ready output interface to the parallel datapath.
- Flags words lost to backpressure (overrun) and frames cut short by an early frame start (frame_err).

Parameters:
- WIDTH, 8, bits per serial frame / output word width (legal range 2..32).
- CNT_W, $clog2(WIDTH), width of internal bit counter.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- areset  input  1  asynchronous, active-high reset.
- bit_valid  input  1  bit_in carries a serial bit this cycle.
- bit_in  input  1  serial data bit (complementer z), LSB first.
- frame_start  input  1  qualifies bit_in as bit 0 of a new frame; only meaningful with bit_valid.
- word_out  output  WIDTH  assembled word.
- word_valid  output  1  word_out holds an unconsumed word.
- word_ready  input  1  downstream accepts word_out this cycle.
- overrun  output  1  sticky: completed word dropped because output register was occupied.
- frame_err  output  1  sticky: frame_start arrived before the previous frame completed.
- flag_clr  input  1  synchronous clear of overrun and frame_err.

Behaviour:
- Reset (areset=1, asynchronous):
  - state=IDLE, shift register=0, count=0.
  - word_out=0, word_valid=0, overrun=0, frame_err=0.
  - A reset mid-frame discards the partial word and any held word.
- Collector FSM, states IDLE and COLLECT:
  - IDLE: bit_valid&&frame_start -> shift in bit, count=1, go COLLECT. bit_valid without frame_start is ignored.
  - COLLECT, bit_valid && !frame_start: shift in bit, count++.
  - COLLECT, bit_valid && frame_start: discard partial word, set frame_err, restart with this bit as bit 0 (count=1), stay COLLECT.
  - COLLECT, bit_valid=0: hold all state; gaps of any length are allowed.
  - COLLECT, completion: on the bit that makes count==WIDTH, the word is complete; go IDLE, count=0.
- Shift rule: shift right, new bit enters at MSB. After WIDTH shifts, bit received first sits at word bit 0.
- Latency: word_out/word_valid update on the same edge that samples the WIDTH-th bit, so word_valid is visible the cycle after the final bit is presented.
- Output register:
  - Separate from the shift register, so collection of the next frame proceeds while a word is held.
  - Transfer occurs when word_valid && word_ready; word_valid then falls next edge unless a new word completes the same edge.
  - Completion with word_valid=0: load word_out, word_valid=1.
  - Completion with word_valid=1 && word_ready=1: load new word, word_valid stays 1, no overrun.
  - Completion with word_valid=1 && word_ready=0: new word dropped, word_out unchanged, overrun=1.
- word_out is stable while word_valid=1 && word_ready=0.
- Flags:
  - Sticky, cleared only by flag_clr or areset.
  - flag_clr coincident with a new set event: set wins.
- A frame never completed is never presented. frame_start on completion edge of previous frame is impossible: completion requires the WIDTH-th bit, which is non-frame_start.

Test Plan:
- Complementer input 0x14 yields z stream 0,0,1,1,0,1,1,1. Feed this back-to-back with frame_start on first bit, word_ready=1 -> word_out=0xEC, word_valid high exactly 1 cycle, edge after 8th bit.
- Same stream with bit_valid low for 3 cycles between bits 2 and 3 -> word_out=0xEC, no flags.
- word_ready=0: frame 0xEC, then frame 0x5A -> word_out stays 0xEC, word_valid=1, overrun=1. Raise word_ready -> 0xEC accepted, word_valid=0. flag_clr -> overrun=0.
- 3 bits of a frame, then new frame_start + bits of 0x01 -> frame_err=1, word_out=0x01, only one word_valid pulse.
- areset asserted after 5 bits, with 0xEC held and unread -> all outputs 0 immediately. A following full frame 0x80 -> word_out=0x80, flags 0.
- word_valid=1 with word_ready=1 on the same edge frame 0x33 completes -> old word accepted, word_out=0x33, word_valid stays 1, overrun=0.
